// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the sequencers that borrow it:
// widths, iteration count, ALU opcodes and the multiply FSM states.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int ITER_N = 16;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ORR = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement magnitude; 16'h8000 maps to 16'h8000, read as unsigned.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// 16x16 shift-add multiplier that sequences an external shared ALU, 16 iterations.
// Define ALU_MUL_SIGNED_EN to add the op_signed port (sign-magnitude signed multiply).
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
`ifdef ALU_MUL_SIGNED_EN
  input  logic                  op_signed,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result,
  output logic [DATA_W-1:0]     alu_x,
  output logic [DATA_W-1:0]     alu_y,
  input  logic [DATA_W-1:0]     alu_z,
  output logic                  alu_c_in,
  input  logic                  alu_c_out,
  output logic [2:0]            alu_op
);

  state_t                r_state;
  logic [DATA_W-1:0]     r_a;
  logic [2*DATA_W-1:0]   r_p;
  logic [2*DATA_W-1:0]   r_result;
  logic [4:0]            r_cnt;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_calc;
  logic [DATA_W-1:0]     w_a_ld;
  logic [DATA_W-1:0]     w_b_ld;
  logic [2*DATA_W-1:0]   w_p_calc;
  logic [2*DATA_W-1:0]   w_p_fix;

`ifdef ALU_MUL_SIGNED_EN
  logic                  r_neg;
  logic                  w_neg_ld;

  // Signed operands are multiplied as magnitudes; the sign is restored in FIX.
  assign w_a_ld   = op_signed ? mag(op_a) : op_a;
  assign w_b_ld   = op_signed ? mag(op_b) : op_b;
  assign w_neg_ld = op_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
  assign w_p_fix  = r_neg ? (~r_p + 1'b1) : r_p;
`else
  assign w_a_ld   = op_a;
  assign w_b_ld   = op_b;
  assign w_p_fix  = r_p;
`endif

  // One shift-add step: the ALU carry becomes the new top bit of P.
  assign w_p_calc = r_p[0] ? {alu_c_out, alu_z, r_p[DATA_W-1:1]}
                           : {1'b0, r_p[2*DATA_W-1:1]};

  assign w_calc   = (r_state == CALC);
  assign alu_op   = w_calc ? ALU_ADD : ALU_AND;
  assign alu_x    = w_calc ? r_p[2*DATA_W-1:DATA_W] : '0;
  assign alu_y    = w_calc ? r_a : '0;
  assign alu_c_in = 1'b0;

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_p      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef ALU_MUL_SIGNED_EN
      r_neg    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= w_a_ld;
            r_p     <= {{DATA_W{1'b0}}, w_b_ld};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
`ifdef ALU_MUL_SIGNED_EN
            r_neg   <= w_neg_ld;
`endif
          end
        end
        CALC: begin
          r_p   <= w_p_calc;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(ITER_N - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_p      <= w_p_fix;
          r_result <= w_p_fix;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-004 SHALL have port op_a, input, 16 bits: multiplicand.
REQ-005 SHALL have port op_b, input, 16 bits: multiplier.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when the result becomes valid.
REQ-008 SHALL have port result, output, 32 bits: product {hi, lo}.
REQ-009 SHALL have ports alu_x, alu_y, alu_z, alu_c_in, alu_c_out and alu_op, which drive and observe the shared 16-bit ALU:
- alu_x, output, 16 bits.
- alu_y, output, 16 bits.
- alu_z, input, 16 bits.
- alu_c_in, output, 1 bit.
- alu_c_out, input, 1 bit.
- alu_op, output, 3 bits.

Function
REQ-010 SHALL implement the FSM states IDLE, CALC, FIX and DONE:
- IDLE -> CALC on start.
- CALC -> FIX after iteration 16.
- FIX -> DONE.
- DONE -> IDLE unconditionally.
REQ-011 SHALL, on accepting start, latch op_a into register A, load the product register P = {16'h0000, op_b}, and clear the 5-bit iteration counter.
REQ-012 SHALL perform one iteration per CALC cycle:
- Drive alu_op=3'b010 (ADD), alu_x=P[31:16], alu_y=A and alu_c_in=0.
- If P[0]=1, P <= {alu_c_out, alu_z, P[15:1]}.
- If P[0]=0, P <= {1'b0, P[31:1]}.
REQ-013 SHALL drive alu_op=3'b000, alu_x=0, alu_y=0 and alu_c_in=0 in every state other than CALC.
REQ-014 SHALL hold P unchanged in FIX when ALU_MUL_SIGNED_EN is undefined (FIX is a pass-through cycle).
REQ-015 SHALL assert done for exactly the DONE cycle, with result = P valid in that cycle.
REQ-016 SHALL hold result stable after DONE until the next start is accepted.
REQ-017 SHALL have a fixed latency: start sampled at edge N, busy high from edge N+1, done high in the cycle after edge N+18.
REQ-018 SHALL ignore start while busy=1; no queuing, no restart.
REQ-019 SHALL ignore start in the DONE cycle; start is accepted only from IDLE, so back-to-back operations are spaced 19 cycles apart minimum.
REQ-020 SHALL produce the arithmetic result modulo 2^32 with no overflow flag; the 16x16 product always fits.
REQ-021 SHALL sample op_a and op_b only at acceptance; later changes do not affect the running operation.

Reset
REQ-022 SHALL, on rst_n=0 (asynchronous), force state=IDLE, busy=0, done=0, result=32'h0, P=0, A=0 and counter=0.
REQ-023 SHALL abort any operation in progress on reset mid-operation, with no done pulse.
REQ-024 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL support macro ALU_MUL_SIGNED_EN, which adds input port op_signed (1 bit), sampled with start.
REQ-026 SHALL, with ALU_MUL_SIGNED_EN defined and op_signed=1:
- At acceptance, replace A and P[15:0] with the magnitudes of op_a and op_b.
- Record neg = op_a[15] ^ op_b[15].
- In FIX, P <= two's complement of P when neg=1, computed with local 32-bit logic and not with the ALU.
REQ-027 SHALL, without ALU_MUL_SIGNED_EN, have no op_signed port and perform unsigned operation only; latency is identical in both builds.

Structure
REQ-028 SHALL place in shared package alu_pkg:
- Data width 16.
- Iteration count 16.
- ALUOp constants: AND 3'b000, ORR 3'b001, ADD 3'b010, SUB 3'b011, SLT 3'b111.
- The FSM state enum.
REQ-029 SHALL contain no sub-module; the ALU is external and connected at the datapath level, so it can be shared by other sequencers.

Verification
REQ-030 SHALL cover: op_a=3, op_b=5, start at cycle 0 -> done at cycle 18, result=32'h0000000F, busy high cycles 1-18.
REQ-031 SHALL cover: op_a=16'hFFFF, op_b=16'hFFFF -> result=32'hFFFE0001; the alu_c_out carry is propagated into P[31].
REQ-032 SHALL cover: op_a=16'h1234, op_b=0 -> result=0 after full latency; start pulsed at cycle 5 while busy -> ignored, single done.
REQ-033 SHALL cover: rst_n low at cycle 7 of an operation -> busy=0, done never pulses, result=0; a new start of 2x2 -> result=4.
REQ-034 SHALL cover, with ALU_MUL_SIGNED_EN defined: op_a=16'hFFFD (-3), op_b=5, op_signed=1 -> result=32'hFFFFFFF1; same operands with op_signed=0 -> result=32'h0004FFF1.
REQ-035 SHALL cover: alu_op equals 3'b010 only during CALC cycles, and 3'b000 in IDLE, FIX and DONE.
